// File: rtl/layer_sequencer_pkg.sv
// Layer sequencer shared definitions: FSM encoding,
// layer code geometry and program constants.
package layer_sequencer_pkg;

  localparam int CODE_W       = 16;
  localparam int LAYER_CODE_W = 96;

  localparam int LIF_THRD_LSB   = 0;
  localparam int BIAS_SCALE_LSB = 16;
  localparam int IN_CH_LSB      = 32;
  localparam int OUT_CH_LSB     = 48;
  localparam int IMG_SIZE_LSB   = 64;
  localparam int LAYER_TYPE_LSB = 80;

  localparam logic [CODE_W-1:0] MAXPOOL_CODE = 16'h0001;
  localparam int                LEN_CODE     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISPATCH,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/layer_sequencer.sv
// SPS layer sequencer: fetches one layer code at a time,
// launches conv or maxpool, and walks the program to its end.
module layer_sequencer #(
  parameter int CODE_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              start,
  output logic              code_ready,
  input  logic              code_valid,
  input  logic              fetch_done,
  input  logic              in_or_maxpool,
  input  logic [CODE_W-1:0] in_lif_thrd,
  input  logic [CODE_W-1:0] in_bias_scale,
  input  logic [CODE_W-1:0] in_ch,
  input  logic [CODE_W-1:0] in_out_ch,
  input  logic [CODE_W-1:0] in_img_size,
  output logic [CODE_W-1:0] cfg_lif_thrd,
  output logic [CODE_W-1:0] cfg_bias_scale,
  output logic [CODE_W-1:0] cfg_in_ch,
  output logic [CODE_W-1:0] cfg_out_ch,
  output logic [CODE_W-1:0] cfg_img_size,
  output logic [CODE_W-1:0] cfg_out_img_size,
  output logic              conv_start,
  output logic              pool_start,
  input  logic              conv_done,
  input  logic              pool_done,
  output logic [IDX_W-1:0]  layer_idx,
  output logic              busy,
  output logic              cfg_err,
  output logic              SPS_part_done
);

  import layer_sequencer_pkg::*;

  seq_state_t        r_state;
  logic              r_code_ready;
  logic              r_conv_start;
  logic              r_pool_start;
  logic              r_part_done;
  logic              r_busy;
  logic              r_cfg_err;
  logic              r_skip;
  logic              r_is_pool;
  logic [IDX_W-1:0]  r_layer_idx;
  logic [CODE_W-1:0] r_lif_thrd;
  logic [CODE_W-1:0] r_bias_scale;
  logic [CODE_W-1:0] r_in_ch;
  logic [CODE_W-1:0] r_out_ch;
  logic [CODE_W-1:0] r_img_size;
  logic [CODE_W-1:0] r_out_img_size;

  logic              w_hs;
  logic              w_zero_dim;
  logic              w_odd_pool;
  logic              w_skip;
  logic              w_done;
  logic [CODE_W-1:0] w_out_img;

  // Launch decision is taken at the handshake so the
  // registered start pulse lines up with DISPATCH.
  assign w_hs       = code_valid && r_code_ready;
  assign w_zero_dim = (in_ch == '0) || (in_out_ch == '0)
                   || (in_img_size == '0);
  assign w_odd_pool = in_or_maxpool && in_img_size[0];
  assign w_skip     = w_zero_dim || w_odd_pool;
  assign w_out_img  = in_or_maxpool ? (in_img_size >> 1)
                                    : in_img_size;
  assign w_done     = r_is_pool ? pool_done : conv_done;

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_state        <= ST_IDLE;
      r_code_ready   <= 1'b0;
      r_conv_start   <= 1'b0;
      r_pool_start   <= 1'b0;
      r_part_done    <= 1'b0;
      r_busy         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_skip         <= 1'b0;
      r_is_pool      <= 1'b0;
      r_layer_idx    <= '0;
      r_lif_thrd     <= '0;
      r_bias_scale   <= '0;
      r_in_ch        <= '0;
      r_out_ch       <= '0;
      r_img_size     <= '0;
      r_out_img_size <= '0;
    end else begin
      r_conv_start <= 1'b0;
      r_pool_start <= 1'b0;
      r_part_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_REQ;
            r_busy       <= 1'b1;
            r_code_ready <= 1'b1;
            r_layer_idx  <= '0;
            r_cfg_err    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (w_hs) begin
            r_state        <= ST_DISPATCH;
            r_code_ready   <= 1'b0;
            r_lif_thrd     <= in_lif_thrd;
            r_bias_scale   <= in_bias_scale;
            r_in_ch        <= in_ch;
            r_out_ch       <= in_out_ch;
            r_img_size     <= in_img_size;
            r_out_img_size <= w_out_img;
            r_is_pool      <= in_or_maxpool;
            r_skip         <= w_skip;
            if (w_skip)
              r_cfg_err <= 1'b1;
            else if (in_or_maxpool)
              r_pool_start <= 1'b1;
            else
              r_conv_start <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          r_state <= r_skip ? ST_CHECK : ST_RUN;
        end
        ST_RUN: begin
          if (w_done)
            r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (fetch_done) begin
            r_state     <= ST_DONE;
            r_part_done <= 1'b1;
          end else begin
            r_state      <= ST_REQ;
            r_code_ready <= 1'b1;
            r_layer_idx  <= r_layer_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign code_ready       = r_code_ready;
  assign conv_start       = r_conv_start;
  assign pool_start       = r_pool_start;
  assign SPS_part_done    = r_part_done;
  assign busy             = r_busy;
  assign cfg_err          = r_cfg_err;
  assign layer_idx        = r_layer_idx;
  assign cfg_lif_thrd     = r_lif_thrd;
  assign cfg_bias_scale   = r_bias_scale;
  assign cfg_in_ch        = r_in_ch;
  assign cfg_out_ch       = r_out_ch;
  assign cfg_img_size     = r_img_size;
  assign cfg_out_img_size = r_out_img_size;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: fetcher/ROM and engine models,
// launch scoreboard and program-level pulse accounting.
module tb_layer_sequencer;

  typedef struct {
    logic        mp;
    logic [15:0] lif;
    logic [15:0] bias;
    logic [15:0] ich;
    logic [15:0] och;
    logic [15:0] img;
  } code_t;

  typedef struct {
    logic        mp;
    logic [4:0]  idx;
    logic [15:0] ich;
    logic [15:0] och;
    logic [15:0] img;
    logic [15:0] oimg;
    logic [15:0] lif;
    logic [15:0] bias;
  } exp_t;

  logic        s_clk = 1'b0;
  logic        s_rst;
  logic        start;
  logic        code_ready;
  logic        code_valid;
  logic        fetch_done;
  logic        in_or_maxpool;
  logic [15:0] in_lif_thrd, in_bias_scale, in_ch;
  logic [15:0] in_out_ch, in_img_size;
  logic [15:0] cfg_lif_thrd, cfg_bias_scale, cfg_in_ch;
  logic [15:0] cfg_out_ch, cfg_img_size, cfg_out_img_size;
  logic        conv_start, pool_start;
  logic        conv_done, pool_done;
  logic [4:0]  layer_idx;
  logic        busy, cfg_err, SPS_part_done;

  code_t       rom [32];
  int          rom_len = 0;
  logic [4:0]  f_addr;
  int          conv_cnt = 0;
  int          pool_cnt = 0;
  logic        m_conv_done = 1'b0;
  logic        m_pool_done = 1'b0;
  logic        inj_pool = 1'b0;

  exp_t        sb [$];
  exp_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  int          mon_conv = 0, mon_pool = 0;
  int          mon_done = 0, mon_hs = 0;
  int          exp_conv, exp_pool;
  logic        exp_err;

  always #5 s_clk = ~s_clk;

  layer_sequencer #(.CODE_W(16), .IDX_W(5)) dut (
    .s_clk            (s_clk),
    .s_rst            (s_rst),
    .start            (start),
    .code_ready       (code_ready),
    .code_valid       (code_valid),
    .fetch_done       (fetch_done),
    .in_or_maxpool    (in_or_maxpool),
    .in_lif_thrd      (in_lif_thrd),
    .in_bias_scale    (in_bias_scale),
    .in_ch            (in_ch),
    .in_out_ch        (in_out_ch),
    .in_img_size      (in_img_size),
    .cfg_lif_thrd     (cfg_lif_thrd),
    .cfg_bias_scale   (cfg_bias_scale),
    .cfg_in_ch        (cfg_in_ch),
    .cfg_out_ch       (cfg_out_ch),
    .cfg_img_size     (cfg_img_size),
    .cfg_out_img_size (cfg_out_img_size),
    .conv_start       (conv_start),
    .pool_start       (pool_start),
    .conv_done        (conv_done),
    .pool_done        (pool_done),
    .layer_idx        (layer_idx),
    .busy             (busy),
    .cfg_err          (cfg_err),
    .SPS_part_done    (SPS_part_done)
  );

  assign in_or_maxpool = rom[f_addr].mp;
  assign in_lif_thrd   = rom[f_addr].lif;
  assign in_bias_scale = rom[f_addr].bias;
  assign in_ch         = rom[f_addr].ich;
  assign in_out_ch     = rom[f_addr].och;
  assign in_img_size   = rom[f_addr].img;
  assign conv_done     = m_conv_done;
  assign pool_done     = m_pool_done | inj_pool;

  // fetcher: valid is registered ready, rewinds on part done
  always @(posedge s_clk) begin
    if (s_rst) begin
      code_valid <= 1'b0;
      f_addr     <= '0;
      fetch_done <= 1'b0;
    end else begin
      code_valid <= code_ready;
      if (SPS_part_done)
        f_addr <= '0;
      else if (code_ready && code_valid)
        f_addr <= f_addr + 5'd1;
      fetch_done <= (f_addr == 5'(rom_len));
    end
  end

  // engines: done 10 cycles after start, never cancelled
  always @(posedge s_clk) begin
    m_conv_done <= (conv_cnt == 1);
    m_pool_done <= (pool_cnt == 1);
    if (conv_start) conv_cnt <= 9;
    else if (conv_cnt > 0) conv_cnt <= conv_cnt - 1;
    if (pool_start) pool_cnt <= 9;
    else if (pool_cnt > 0) pool_cnt <= pool_cnt - 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge s_clk) begin
    if (!s_rst) begin
      if (code_ready && code_valid) mon_hs++;
      if (conv_start) mon_conv++;
      if (pool_start) mon_pool++;
      if (SPS_part_done) mon_done++;
      if (conv_start && pool_start) chk("both_start", 1, 0);
      if (conv_start || pool_start) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_type", {63'd0, pool_start}, {63'd0, e.mp});
          chk("sb_idx", {59'd0, layer_idx}, {59'd0, e.idx});
          chk("sb_geom",
              {cfg_in_ch, cfg_out_ch, cfg_img_size, cfg_out_img_size},
              {e.ich, e.och, e.img, e.oimg});
          chk("sb_scal", {32'd0, cfg_lif_thrd, cfg_bias_scale},
              {32'd0, e.lif, e.bias});
        end
      end
    end
  end

  task automatic set_layer(input int i, input logic mp,
                           input int ich, input int och,
                           input int img);
    rom[i].mp   = mp;
    rom[i].lif  = 16'(100 + i);
    rom[i].bias = 16'(200 + 7 * i);
    rom[i].ich  = 16'(ich);
    rom[i].och  = 16'(och);
    rom[i].img  = 16'(img);
  endtask

  task automatic load_rom_a();
    set_layer(0, 1'b0, 3, 32, 64);
    set_layer(1, 1'b0, 32, 64, 64);
    set_layer(2, 1'b1, 64, 64, 64);
    rom_len = 3;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 0);
    chk({tag, "_ctl"},
        {58'd0, code_ready, conv_start, pool_start,
         SPS_part_done, cfg_err, 1'b0}, 0);
    chk({tag, "_idx"}, {59'd0, layer_idx}, 0);
    chk({tag, "_cfg_a"},
        {cfg_in_ch, cfg_out_ch, cfg_img_size, cfg_out_img_size}, 0);
    chk({tag, "_cfg_b"}, {32'd0, cfg_lif_thrd, cfg_bias_scale}, 0);
  endtask

  // pushes expected launches, pulses start, checks first-layer timing
  task automatic begin_prog();
    logic skip;
    exp_t x;
    exp_conv = 0;
    exp_pool = 0;
    exp_err  = 1'b0;
    mon_conv = 0;
    mon_pool = 0;
    mon_done = 0;
    mon_hs   = 0;
    for (int i = 0; i < rom_len; i++) begin
      skip = (rom[i].ich == 0) || (rom[i].och == 0) ||
             (rom[i].img == 0) || (rom[i].mp && rom[i].img[0]);
      if (skip) begin
        exp_err = 1'b1;
      end else begin
        x.mp   = rom[i].mp;
        x.idx  = 5'(i);
        x.ich  = rom[i].ich;
        x.och  = rom[i].och;
        x.img  = rom[i].img;
        x.oimg = rom[i].mp ? 16'(rom[i].img / 2) : rom[i].img;
        x.lif  = rom[i].lif;
        x.bias = rom[i].bias;
        sb.push_back(x);
        if (rom[i].mp) exp_pool++;
        else exp_conv++;
      end
    end
    @(posedge s_clk); #1;
    chk("pre_busy", {63'd0, busy}, 0);
    chk("pre_addr", {59'd0, f_addr}, 0);
    start = 1'b1;
    @(posedge s_clk); #1;
    start = 1'b0;
    chk("t1_ready", {63'd0, code_ready}, 1);
    chk("t1_busy", {63'd0, busy}, 1);
    chk("t1_err_clr", {63'd0, cfg_err}, 0);
    chk("t1_idx", {59'd0, layer_idx}, 0);
    @(posedge s_clk); #1;
    chk("t2_ready", {63'd0, code_ready}, 1);
    chk("t2_launch", {62'd0, conv_start, pool_start}, 0);
    @(posedge s_clk); #1;
    chk("t3_ready", {63'd0, code_ready}, 0);
    chk("t3_launch", {62'd0, conv_start, pool_start},
        rom[0].mp ? 64'd1 : 64'd2);
  endtask

  task automatic wait_prog(input int kstart);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge s_clk); #1;
      if (mon_done > 0) break;
      if (kstart > 0 && i == kstart) start = 1'b1;
      if (i == kstart + 1) start = 1'b0;
    end
    start = 1'b0;
    if (i >= 3000) chk("prog_timeout", 0, 1);
  endtask

  task automatic check_prog(input string tag);
    chk({tag, "_conv"}, 64'(mon_conv), 64'(exp_conv));
    chk({tag, "_pool"}, 64'(mon_pool), 64'(exp_pool));
    chk({tag, "_done"}, 64'(mon_done), 1);
    chk({tag, "_hs"}, 64'(mon_hs), 64'(rom_len));
    chk({tag, "_sb_left"}, 64'(sb.size()), 0);
    chk({tag, "_err"}, {63'd0, cfg_err}, {63'd0, exp_err});
    chk({tag, "_last_idx"}, {59'd0, layer_idx}, 64'(rom_len - 1));
  endtask

  initial begin
    s_rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    chk_reset("rst");
    s_rst = 1'b0;

    // full program with a stray start while busy
    load_rom_a();
    begin_prog();
    wait_prog(15);
    check_prog("run1");

    // restart in the first IDLE cycle after part done
    begin_prog();
    wait_prog(0);
    check_prog("run2");

    // zero-channel and odd-size maxpool layers are skipped
    set_layer(0, 1'b0, 3, 32, 64);
    set_layer(1, 1'b0, 0, 32, 64);
    set_layer(2, 1'b1, 64, 64, 33);
    set_layer(3, 1'b0, 32, 64, 16);
    rom_len = 4;
    begin_prog();
    wait_prog(0);
    check_prog("skip");
    repeat (3) @(posedge s_clk);
    #1;
    chk("skip_err_sticky", {63'd0, cfg_err}, 1);

    // foreign pool_done while a conv layer runs
    set_layer(0, 1'b0, 4, 8, 8);
    rom_len = 1;
    fork
      begin
        begin_prog();
        wait_prog(0);
        check_prog("inj");
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge s_clk); #1;
          if (mon_conv > 0) break;
        end
        chk("inj_saw_conv", 64'(mon_conv), 1);
        @(posedge s_clk); #1;
        inj_pool = 1'b1;
        @(posedge s_clk); #1;
        inj_pool = 1'b0;
        repeat (4) @(posedge s_clk);
        #1;
        chk("inj_busy", {63'd0, busy}, 1);
        chk("inj_no_done", 64'(mon_done), 0);
      end
    join

    // reset while a layer runs, then a clean restart
    load_rom_a();
    begin_prog();
    for (int i = 0; i < 50; i++) begin
      @(negedge s_clk); #1;
      if (mon_conv > 0) break;
    end
    repeat (3) @(posedge s_clk);
    #1;
    chk("mid_busy", {63'd0, busy}, 1);
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    chk_reset("mid_rst");
    s_rst = 1'b0;
    sb.delete();
    repeat (25) @(posedge s_clk);
    #1;
    chk("stale_done_idle", {63'd0, busy}, 0);
    begin_prog();
    wait_prog(0);
    check_prog("rerun");

    repeat (3) @(posedge s_clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
